// File: rtl/aes_pkg.sv
// Shared constants and GF(2^8) helpers for the AES-128 encrypt core.
// Byte n of a block sits at bits [127-8n -: 8], n = 4*col + row.
package aes_pkg;

   localparam int NR      = 10;
   localparam int NK      = 4;
   localparam int BLOCK_W = 128;

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      v = 8'h00;
      unique case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      {a0, a1, a2, a3} = c;
      b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      return {b0, b1, b2, b3};
   endfunction

   // lsb position of s[r,c] inside a 128-bit block
   function automatic int bidx(input int r, input int c);
      return BLOCK_W - 8 - 8 * (NK * c + r);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
// Row chosen by the high nibble, byte picked by the low nibble.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   logic [127:0] row;

   always_comb begin
      row = '0;
      unique case (a[7:4])
         4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
         4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
         4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
         4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
         4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
         4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
         4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
         4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
         4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
         4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
         4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
         4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
         4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
         4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
         4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
         4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
         default: row = '0;
      endcase
      y = row[{~a[3:0], 3'b000} +: 8];
   end

endmodule

// File: rtl/aes128_encrypt_core.sv
// Free-running iterative AES-128 encryptor, one round per clock.
// Loads state^key, runs 10 rounds, publishes out, then reloads.
module aes128_encrypt_core
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] state,
   input  logic [127:0] key,
   output logic [127:0] out
);

   logic [127:0] st;
   logic [127:0] rk;
   logic [3:0]   rnd;
   logic [127:0] out_r;

   logic [7:0]   sb [16];
   logic [7:0]   kb [4];
   logic [127:0] sr;
   logic [127:0] mx;
   logic [127:0] nk;
   logic [31:0]  rot;
   logic [31:0]  tmp;
   logic [31:0]  n0, n1, n2, n3;

   for (genvar g = 0; g < 16; g++) begin : g_sb
      aes_sbox u_sb (.a(st[127-8*g -: 8]), .y(sb[g]));
   end

   assign rot = {rk[23:0], rk[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_kb
      aes_sbox u_kb (.a(rot[31-8*g -: 8]), .y(kb[g]));
   end

   always_comb begin
      sr = '0;
      mx = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[bidx(r, c) +: 8] = sb[4 * ((c + r) % 4) + r];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mx[96-32*c +: 32] = mix_column(sr[96-32*c +: 32]);
      end
   end

   // key schedule step for the round being entered
   assign tmp = {kb[0] ^ rcon(rnd), kb[1], kb[2], kb[3]};
   assign n0  = rk[127:96] ^ tmp;
   assign n1  = rk[95:64] ^ n0;
   assign n2  = rk[63:32] ^ n1;
   assign n3  = rk[31:0] ^ n2;
   assign nk  = {n0, n1, n2, n3};

   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= '0;
         rk    <= '0;
         rnd   <= '0;
         out_r <= '0;
      end else begin
         unique case (1'b1)
            (rnd == 4'd0 || rnd > 4'(NR)): begin
               st  <= state ^ key;
               rk  <= key;
               rnd <= 4'd1;
            end
            (rnd == 4'(NR)): begin
               out_r <= sr ^ nk;
               rnd   <= 4'd0;
            end
            default: begin
               st  <= mx ^ nk;
               rk  <= nk;
               rnd <= rnd + 4'd1;
            end
         endcase
      end
   end

   assign out = out_r;

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Directed-vector bench for aes128_encrypt_core.
// Known-answer vectors, latency, input isolation, reset abort, steady state.
module tb_aes128_encrypt_core;

   logic         clk;
   logic         rst;
   logic [127:0] state;
   logic [127:0] key;
   logic [127:0] out;

   int vecs;
   int errs;

   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   aes128_encrypt_core dut (
      .clk  (clk),
      .rst  (rst),
      .state(state),
      .key  (key),
      .out  (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      edges(n);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      state = PT_B;
      key   = KEY_B;
      do_reset(2);
      vecs++;
      if (out !== 128'h0) begin
         errs++;
         $display("FAIL reset: out=%h want=%h", out, 128'h0);
      end
   endtask

   task automatic test_fips_b;
      state = PT_B;
      key   = KEY_B;
      do_reset(2);
      for (int e = 1; e <= 10; e++) begin
         edges(1);
         vecs++;
         if (out !== 128'h0) begin
            errs++;
            $display("FAIL fips_b_early e=%0d: out=%h want=0", e, out);
         end
      end
      edges(1);
      vecs++;
      if (out !== CT_B) begin
         errs++;
         $display("FAIL fips_b: out=%h want=%h", out, CT_B);
      end
   endtask

   task automatic test_fips_c;
      state = PT_C;
      key   = KEY_C;
      do_reset(1);
      edges(11);
      vecs++;
      if (out !== CT_C) begin
         errs++;
         $display("FAIL fips_c: out=%h want=%h", out, CT_C);
      end
   endtask

   task automatic test_zero;
      state = '0;
      key   = '0;
      do_reset(1);
      edges(11);
      vecs++;
      if (out !== CT_Z) begin
         errs++;
         $display("FAIL zero: out=%h want=%h", out, CT_Z);
      end
   endtask

   task automatic test_input_change;
      state = PT_B;
      key   = KEY_B;
      do_reset(1);
      edges(4);
      state = PT_C;
      key   = KEY_C;
      edges(7);
      vecs++;
      if (out !== CT_B) begin
         errs++;
         $display("FAIL chg_first: out=%h want=%h", out, CT_B);
      end
      edges(10);
      vecs++;
      if (out !== CT_B) begin
         errs++;
         $display("FAIL chg_hold: out=%h want=%h", out, CT_B);
      end
      edges(1);
      vecs++;
      if (out !== CT_C) begin
         errs++;
         $display("FAIL chg_next: out=%h want=%h", out, CT_C);
      end
   endtask

   task automatic test_reset_mid;
      state = PT_B;
      key   = KEY_B;
      do_reset(1);
      edges(11);
      vecs++;
      if (out !== CT_B) begin
         errs++;
         $display("FAIL mid_pre: out=%h want=%h", out, CT_B);
      end
      edges(5);
      state = PT_C;
      key   = KEY_C;
      do_reset(1);
      vecs++;
      if (out !== 128'h0) begin
         errs++;
         $display("FAIL mid_rst: out=%h want=0", out);
      end
      edges(10);
      vecs++;
      if (out !== 128'h0) begin
         errs++;
         $display("FAIL mid_early: out=%h want=0", out);
      end
      edges(1);
      vecs++;
      if (out !== CT_C) begin
         errs++;
         $display("FAIL mid_after: out=%h want=%h", out, CT_C);
      end
   endtask

   task automatic test_steady;
      state = '0;
      key   = '0;
      do_reset(1);
      edges(11);
      for (int e = 0; e < 55; e++) begin
         vecs++;
         if (out !== CT_Z) begin
            errs++;
            $display("FAIL steady e=%0d: out=%h want=%h", e, out, CT_Z);
         end
         edges(1);
      end
   endtask

   initial begin
      vecs  = 0;
      errs  = 0;
      rst   = 1'b1;
      state = '0;
      key   = '0;
      test_reset;
      test_fips_b;
      test_fips_c;
      test_zero;
      test_input_change;
      test_reset_mid;
      test_steady;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
